// File: rtl/hsv_pwm_fader_if.sv
// Control and LED/observation signals of the HSV PWM fader, grouped for connection.
interface hsv_pwm_fader_if #(
   parameter int PWM_BITS = 8
);
   logic                  en;
   logic                  mode;
   logic [PWM_BITS-1:0]   brightness;
   logic                  RGB_R;
   logic                  RGB_G;
   logic                  RGB_B;
   logic [PWM_BITS+2:0]   hue;
   logic                  hue_tick;

   modport master (
      output en, mode, brightness,
      input  RGB_R, RGB_G, RGB_B, hue, hue_tick
   );

   modport slave (
      input  en, mode, brightness,
      output RGB_R, RGB_G, RGB_B, hue, hue_tick
   );
endinterface

// File: rtl/hsv_pwm_fader.sv
// Walks an RGB LED around the HSV hue circle, either in six discrete steps or as a
// continuous fade, using a brightness-scaled PWM whose duties update only at frame end.
module hsv_pwm_fader #(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 2000000,
   parameter int FADE_CYCLES = 46875
) (
   input  logic           clk,
   input  logic           rst,
   hsv_pwm_fader_if.slave bus
);
   localparam int HUE_W   = PWM_BITS + 3;
   localparam int LIM_MAX = (STEP_CYCLES > FADE_CYCLES) ? STEP_CYCLES : FADE_CYCLES;
   localparam int IVL_W   = (LIM_MAX > 1) ? $clog2(LIM_MAX) : 1;

   localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
   localparam logic [IVL_W-1:0]    STEP_LAST = IVL_W'(STEP_CYCLES - 1);
   localparam logic [IVL_W-1:0]    FADE_LAST = IVL_W'(FADE_CYCLES - 1);
   localparam logic [HUE_W-1:0]    HUE_LAST  = HUE_W'(6 * (2 ** PWM_BITS) - 1);

   // (c * (b+1)) >> PWM_BITS; the product never exceeds 2*PWM_BITS bits.
   function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] c,
                                                 input logic [PWM_BITS-1:0] b);
      logic [PWM_BITS:0]   b1;
      logic [2*PWM_BITS:0] prod;
      b1   = {1'b0, b} + (PWM_BITS+1)'(1);
      prod = (2*PWM_BITS+1)'(c) * (2*PWM_BITS+1)'(b1);
      return prod[2*PWM_BITS-1:PWM_BITS];
   endfunction

   logic [IVL_W-1:0]    ivl_q, ivl_d;
   logic [HUE_W-1:0]    hue_q, hue_d;
   logic                hue_tick_q, hue_tick_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
   logic                rgb_r_q, rgb_r_d, rgb_g_q, rgb_g_d, rgb_b_q, rgb_b_d;

   logic [2:0]          sector;
   logic [PWM_BITS-1:0] frac, fall;
   logic [PWM_BITS-1:0] c_r, c_g, c_b;
   logic                tick;

   assign sector = hue_q[HUE_W-1:PWM_BITS];
   assign frac   = hue_q[PWM_BITS-1:0];
   assign fall   = MAX - frac;

   always_comb begin
      c_r = '0;
      c_g = '0;
      c_b = '0;
      case (sector)
         3'd0:    begin c_r = MAX;  c_g = frac; end
         3'd1:    begin c_r = fall; c_g = MAX;  end
         3'd2:    begin c_g = MAX;  c_b = frac; end
         3'd3:    begin c_g = fall; c_b = MAX;  end
         3'd4:    begin c_r = frac; c_b = MAX;  end
         3'd5:    begin c_r = MAX;  c_b = fall; end
         default: ;
      endcase
   end

   always_comb begin
      // >= rather than == so a switch to the shorter limit ticks at once instead of wrapping.
      tick       = bus.en && (bus.mode ? (ivl_q >= FADE_LAST) : (ivl_q >= STEP_LAST));
      ivl_d      = ivl_q;
      hue_d      = hue_q;
      hue_tick_d = tick;
      if (bus.en) begin
         ivl_d = tick ? '0 : ivl_q + IVL_W'(1);
      end
      if (tick) begin
         if (bus.mode) begin
            hue_d = (hue_q >= HUE_LAST) ? '0 : hue_q + HUE_W'(1);
         end else begin
            hue_d = (sector >= 3'd5) ? '0 : {sector + 3'd1, {PWM_BITS{1'b0}}};
         end
      end

      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      duty_r_d  = duty_r_q;
      duty_g_d  = duty_g_q;
      duty_b_d  = duty_b_q;
      if (pwm_cnt_q == MAX) begin
         duty_r_d = scale(c_r, bus.brightness);
         duty_g_d = scale(c_g, bus.brightness);
         duty_b_d = scale(c_b, bus.brightness);
      end
      rgb_r_d = (pwm_cnt_q < duty_r_q);
      rgb_g_d = (pwm_cnt_q < duty_g_q);
      rgb_b_d = (pwm_cnt_q < duty_b_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ivl_q      <= '0;
         hue_q      <= '0;
         hue_tick_q <= 1'b0;
         pwm_cnt_q  <= '0;
         duty_r_q   <= '0;
         duty_g_q   <= '0;
         duty_b_q   <= '0;
         rgb_r_q    <= 1'b0;
         rgb_g_q    <= 1'b0;
         rgb_b_q    <= 1'b0;
      end else begin
         ivl_q      <= ivl_d;
         hue_q      <= hue_d;
         hue_tick_q <= hue_tick_d;
         pwm_cnt_q  <= pwm_cnt_d;
         duty_r_q   <= duty_r_d;
         duty_g_q   <= duty_g_d;
         duty_b_q   <= duty_b_d;
         rgb_r_q    <= rgb_r_d;
         rgb_g_q    <= rgb_g_d;
         rgb_b_q    <= rgb_b_d;
      end
   end

   assign bus.RGB_R    = rgb_r_q;
   assign bus.RGB_G    = rgb_g_q;
   assign bus.RGB_B    = rgb_b_q;
   assign bus.hue      = hue_q;
   assign bus.hue_tick = hue_tick_q;
endmodule

// File: tb/tb_hsv_pwm_fader.sv
// Directed bench for hsv_pwm_fader with PWM_BITS=4, STEP_CYCLES=5, FADE_CYCLES=2.
module tb_hsv_pwm_fader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   npass = 0;
   int   ntot  = 0;

   hsv_pwm_fader_if #(.PWM_BITS(4)) bus ();

   hsv_pwm_fader #(
      .PWM_BITS   (4),
      .STEP_CYCLES(5),
      .FADE_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      ntot++;
      assert (obs === exp_v) npass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp_v);
   endtask

   // High-cycle counts of R/G/B over 16 consecutive cycles, packed as 0x00RRGGBB.
   task automatic frame(output logic [31:0] rgb);
      int r, g, b;
      r = 0; g = 0; b = 0;
      repeat (16) begin
         @(negedge clk);
         r += int'(bus.RGB_R);
         g += int'(bus.RGB_G);
         b += int'(bus.RGB_B);
      end
      rgb = {8'h00, 8'(r), 8'(g), 8'(b)};
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.hue_tick && n < 20);
   endtask

   task automatic wait_hue(input string tag, input logic [6:0] target, input int bound);
      int n;
      n = 0;
      while (bus.hue !== target && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(bus.hue), 32'(target));
   endtask

   task automatic measure(input string tag, input logic [6:0] target, input logic [31:0] exp_v);
      logic [31:0] x;
      bus.en = 1'b1;
      wait_hue({tag, "_reach"}, target, 300);
      bus.en = 1'b0;
      repeat (40) @(negedge clk);
      frame(x);
      chk(tag, x, exp_v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x;
      int n, t;
      logic [6:0] step_seq [6];
      step_seq = '{7'd16, 7'd32, 7'd48, 7'd64, 7'd80, 7'd0};

      bus.en = 1'b0;
      bus.mode = 1'b0;
      bus.brightness = 4'd15;
      repeat (3) @(negedge clk);
      chk("rst_rgb", 32'({bus.RGB_R, bus.RGB_G, bus.RGB_B}), 32'd0);
      chk("rst_hue", 32'(bus.hue), 32'd0);
      chk("rst_tick", 32'(bus.hue_tick), 32'd0);
      rst = 1'b0;
      frame(x);
      chk("first_frame_dark", x, 32'h0000_0000);
      frame(x);
      chk("second_frame_red", x, 32'h000f_0000);

      // Step mode: tick every 5 cycles, sector-aligned hue sequence with wrap.
      bus.en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_tick(n);
         chk($sformatf("step_period%0d", i), 32'(n), 32'd5);
         chk($sformatf("step_hue%0d", i), 32'(bus.hue), 32'(step_seq[i]));
      end
      measure("col_s1", 7'd16, 32'h000f_0f00);
      measure("col_s2", 7'd32, 32'h0000_0f00);
      measure("col_s3", 7'd48, 32'h0000_0f0f);
      measure("col_s4", 7'd64, 32'h0000_000f);
      measure("col_s5", 7'd80, 32'h000f_000f);
      measure("col_s0", 7'd0,  32'h000f_0000);

      // Fade mode.
      bus.mode = 1'b1;
      measure("fade_h21", 7'd21, 32'h000a_0f00);
      bus.en = 1'b1;
      wait_tick(n);
      chk("fade_period", 32'(n), 32'd2);
      chk("fade_hue22", 32'(bus.hue), 32'd22);
      @(negedge clk);
      bus.en = 1'b0;
      t = 0;
      repeat (20) begin
         @(negedge clk);
         t += int'(bus.hue_tick);
      end
      chk("hold_no_tick", 32'(t), 32'd0);
      chk("hold_hue", 32'(bus.hue), 32'd22);
      bus.en = 1'b1;
      wait_tick(n);
      chk("resume_period", 32'(n), 32'd1);
      chk("resume_hue", 32'(bus.hue), 32'd23);

      wait_hue("reach95", 7'd95, 300);
      wait_tick(n);
      chk("wrap_period", 32'(n), 32'd2);
      chk("wrap_hue", 32'(bus.hue), 32'd0);

      // Fade -> step at a fractional hue snaps to next sector.
      wait_hue("reach21", 7'd21, 100);
      bus.mode = 1'b0;
      wait_tick(n);
      chk("snap_period", 32'(n), 32'd5);
      chk("snap_hue", 32'(bus.hue), 32'd32);

      // Step -> fade with ivl=2, beyond the fade limit: tick on the very next cycle.
      repeat (2) @(negedge clk);
      chk("pre_switch_hue", 32'(bus.hue), 32'd32);
      bus.mode = 1'b1;
      wait_tick(n);
      chk("switch_period", 32'(n), 32'd1);
      chk("switch_hue", 32'(bus.hue), 32'd33);

      // Brightness scaling at hue 0.
      bus.mode = 1'b0;
      bus.en = 1'b1;
      wait_hue("reach0", 7'd0, 100);
      bus.en = 1'b0;
      bus.brightness = 4'd7;
      repeat (40) @(negedge clk);
      frame(x);
      chk("bright7", x, 32'h0007_0000);
      bus.brightness = 4'd0;
      repeat (40) @(negedge clk);
      frame(x);
      chk("bright0", x, 32'h0000_0000);

      // Reset mid-frame while outputs are high.
      bus.brightness = 4'd15;
      measure("pre_rst_col", 7'd16, 32'h000f_0f00);
      n = 0;
      while (bus.RGB_R !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("pre_rst_r_high", 32'(bus.RGB_R), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rgb", 32'({bus.RGB_R, bus.RGB_G, bus.RGB_B}), 32'd0);
      chk("midrst_hue", 32'(bus.hue), 32'd0);
      chk("midrst_tick", 32'(bus.hue_tick), 32'd0);
      rst = 1'b0;
      frame(x);
      chk("post_rst_dark", x, 32'h0000_0000);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
